exec_hazard_ctrl: RTL and testbench

- Pipeline controller that sequences the execute stage.
- Tracks the destination registers of the two instructions in flight ahead of decode (EX slot and MEM slot).
- Drives the executer's operand-forwarding selects (alu_a_src/alu_b_src), load-use stall and post-branch flush.
- Sits between decode and executer; consumes the executer's registered branch redirect.

---
 rtl/exec_ctrl_pkg.sv | 37 +++
 rtl/exec_hazard_ctrl_fwd_select.sv | 27 ++
 rtl/exec_hazard_ctrl.sv | 113 +++++++++++
 tb/tb_exec_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_ctrl_pkg.sv
// Shared types for the execute-stage hazard controller: pipeline slot record,
// forwarding-source encoding and controller FSM states.
package exec_ctrl_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned SRC_W  = 2;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned PERF_W = 16;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_we;
        logic             load;
    } slot_t;

    typedef enum logic [SRC_W-1:0] {
        FWD_REG = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_src_e;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } ctrl_state_e;

    localparam slot_t SLOT_BUBBLE = '0;

    // True when slot s produces register r; x0 and non-writing slots never match.
    // load_ok=0 rejects a load whose data is not yet available in that slot.
    function automatic logic slot_fwd_hit(input slot_t s, input logic [REG_W-1:0] r,
                                          input logic load_ok);
        return s.valid && s.reg_we && (s.rd != '0) && (s.rd == r) && (load_ok || !s.load);
    endfunction

endpackage

// File: rtl/exec_hazard_ctrl_fwd_select.sv
// Per-operand forwarding select and load-use detection against the EX/MEM slots.
module fwd_select
    import exec_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic             rs_used,
    input  slot_t            ex_slot,
    input  slot_t            mem_slot,
    output fwd_src_e         src,
    output logic             load_hit
);

    // Younger producer (EX) wins over older (MEM).
    always_comb begin
        src      = FWD_REG;
        load_hit = 1'b0;
        if (rs_used) begin
            if (slot_fwd_hit(ex_slot, rs, 1'b0)) begin
                src = FWD_EX;
            end else if (slot_fwd_hit(mem_slot, rs, 1'b1)) begin
                src = FWD_MEM;
            end
            load_hit = ex_slot.load && slot_fwd_hit(ex_slot, rs, 1'b1);
        end
    end

endmodule

// File: rtl/exec_hazard_ctrl.sv
// Execute-stage sequencer: tracks EX/MEM destination slots, drives operand
// forwarding, load-use stall, memory back-pressure freeze and post-branch flush.
module exec_hazard_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 3,
    parameter int unsigned XLEN_REGS    = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                dec_valid,
    input  logic [$clog2(XLEN_REGS)-1:0]        dec_rs1,
    input  logic                                dec_rs1_used,
    input  logic [$clog2(XLEN_REGS)-1:0]        dec_rs2,
    input  logic                                dec_rs2_used,
    input  logic [$clog2(XLEN_REGS)-1:0]        dec_rd,
    input  logic                                dec_reg_we,
    input  logic                                dec_load,
    input  logic                                br_taken,
    input  logic                                mem_busy,
    output logic [SRC_W-1:0]                    alu_a_src,
    output logic [SRC_W-1:0]                    alu_b_src,
    output logic                                stall,
    output logic                                flush,
    output logic                                issue,
    output logic [PERF_W-1:0]                   hazard_cnt
);

    ctrl_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    slot_t            ex_slot, mem_slot, dec_slot;
    fwd_src_e         src_a, src_b;
    logic             hit_a, hit_b;
    logic             load_use;

    fwd_select u_fwd_a (
        .rs       (dec_rs1),
        .rs_used  (dec_rs1_used),
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .src      (src_a),
        .load_hit (hit_a)
    );

    fwd_select u_fwd_b (
        .rs       (dec_rs2),
        .rs_used  (dec_rs2_used),
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .src      (src_b),
        .load_hit (hit_b)
    );

    assign alu_a_src = SRC_W'(src_a);
    assign alu_b_src = SRC_W'(src_b);

    // Load-use only matters while issuing; in FLUSH the decode slot is killed anyway.
    assign load_use = dec_valid && (state == S_RUN) && (hit_a || hit_b);
    assign flush    = (state == S_FLUSH);
    assign stall    = reset && (mem_busy || load_use);
    assign issue    = reset && dec_valid && !stall && !flush && (state == S_RUN);

    always_comb begin
        dec_slot        = SLOT_BUBBLE;
        dec_slot.valid  = 1'b1;
        dec_slot.rd     = dec_rd;
        dec_slot.reg_we = dec_reg_we;
        dec_slot.load   = dec_load;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Redirect reloads the dead window from any state; back-pressure freezes the countdown.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (br_taken) begin
            state_nxt = S_FLUSH;
            cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
        end else if (!mem_busy && (state == S_FLUSH)) begin
            if (cnt == '0) begin
                state_nxt = S_RUN;
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_slot    <= SLOT_BUBBLE;
            mem_slot   <= SLOT_BUBBLE;
            hazard_cnt <= '0;
        end else begin
            if (!mem_busy) begin
                mem_slot <= ex_slot;
                ex_slot  <= issue ? dec_slot : SLOT_BUBBLE;
            end
            if (load_use && !mem_busy && (hazard_cnt != '1)) begin
                hazard_cnt <= hazard_cnt + PERF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_exec_hazard_ctrl.sv
// Directed bench for exec_hazard_ctrl: forwarding, load-use, x0 filter,
// branch flush/retrigger, memory back-pressure and async reset mid-flush.
module tb_exec_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic        dec_valid;
    logic [4:0]  dec_rs1;
    logic        dec_rs1_used;
    logic [4:0]  dec_rs2;
    logic        dec_rs2_used;
    logic [4:0]  dec_rd;
    logic        dec_reg_we;
    logic        dec_load;
    logic        br_taken;
    logic        mem_busy;
    logic [1:0]  alu_a_src;
    logic [1:0]  alu_b_src;
    logic        stall;
    logic        flush;
    logic        issue;
    logic [15:0] hazard_cnt;

    int n_vec = 0;
    int n_err = 0;

    exec_hazard_ctrl #(.FLUSH_CYCLES(3), .XLEN_REGS(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .dec_valid    (dec_valid),
        .dec_rs1      (dec_rs1),
        .dec_rs1_used (dec_rs1_used),
        .dec_rs2      (dec_rs2),
        .dec_rs2_used (dec_rs2_used),
        .dec_rd       (dec_rd),
        .dec_reg_we   (dec_reg_we),
        .dec_load     (dec_load),
        .br_taken     (br_taken),
        .mem_busy     (mem_busy),
        .alu_a_src    (alu_a_src),
        .alu_b_src    (alu_b_src),
        .stall        (stall),
        .flush        (flush),
        .issue        (issue),
        .hazard_cnt   (hazard_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input int exp);
        n_vec++;
        assert (obs === 16'(exp))
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, 16'(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input int v, input int r1, input int u1, input int r2, input int u2,
                       input int rd, input int we, input int ld);
        dec_valid    = 1'(v);
        dec_rs1      = 5'(r1);
        dec_rs1_used = 1'(u1);
        dec_rs2      = 5'(r2);
        dec_rs2_used = 1'(u2);
        dec_rd       = 5'(rd);
        dec_reg_we   = 1'(we);
        dec_load     = 1'(ld);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        mem_busy = 1'b0;
        br_taken = 1'b0;
        dec(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_a_src", 16'(alu_a_src), 0);
        chk("rst_b_src", 16'(alu_b_src), 0);
        chk("rst_stall", 16'(stall), 0);
        chk("rst_flush", 16'(flush), 0);
        chk("rst_issue", 16'(issue), 0);
        chk("rst_hazard", hazard_cnt, 0);
        reset = 1'b1;
        tick();

        // Back-to-back ALU dependency
        dec(1, 1, 0, 2, 0, 5, 1, 0);
        chk("alu_issue", 16'(issue), 1);
        chk("alu_src_a0", 16'(alu_a_src), 0);
        tick();
        dec(1, 5, 1, 6, 1, 6, 1, 0);
        chk("b2b_ex_a", 16'(alu_a_src), 1);
        chk("b2b_b_reg", 16'(alu_b_src), 0);
        chk("b2b_stall", 16'(stall), 0);
        chk("b2b_issue", 16'(issue), 1);
        tick();
        dec(1, 5, 1, 6, 1, 8, 1, 0);
        chk("mem_fwd_a", 16'(alu_a_src), 2);
        chk("ex_fwd_b", 16'(alu_b_src), 1);
        tick();
        dec(1, 8, 0, 6, 1, 0, 0, 0);
        chk("unused_a", 16'(alu_a_src), 0);
        chk("mem_fwd_b", 16'(alu_b_src), 2);
        tick();

        // x0 filter: ALU producer and load producer writing x0
        dec(1, 0, 0, 0, 0, 0, 1, 0);
        tick();
        dec(1, 0, 1, 0, 0, 9, 1, 0);
        chk("x0_a", 16'(alu_a_src), 0);
        chk("x0_stall", 16'(stall), 0);
        tick();
        dec(1, 0, 0, 0, 0, 0, 1, 1);
        tick();
        dec(1, 0, 1, 9, 1, 0, 0, 0);
        chk("x0_load_stall", 16'(stall), 0);
        chk("x0_load_issue", 16'(issue), 1);
        chk("x0_load_b_mem", 16'(alu_b_src), 2);
        tick();

        // Load-use
        dec(1, 0, 0, 0, 0, 7, 1, 1);
        tick();
        dec(1, 3, 0, 7, 1, 10, 1, 0);
        chk("lu_stall", 16'(stall), 1);
        chk("lu_issue", 16'(issue), 0);
        chk("lu_b_src", 16'(alu_b_src), 0);
        chk("lu_hazard_pre", hazard_cnt, 0);
        tick();
        chk("lu_after_stall", 16'(stall), 0);
        chk("lu_after_issue", 16'(issue), 1);
        chk("lu_after_b_mem", 16'(alu_b_src), 2);
        chk("lu_hazard", hazard_cnt, 1);
        tick();

        // Memory back-pressure with a dependent pair in flight
        dec(1, 10, 1, 0, 0, 11, 1, 0);
        chk("mb_pre_a", 16'(alu_a_src), 1);
        tick();
        mem_busy = 1'b1;
        dec(1, 10, 1, 11, 1, 12, 1, 0);
        for (int i = 0; i < 4; i++) begin
            chk("mb_stall", 16'(stall), 1);
            chk("mb_issue", 16'(issue), 0);
            chk("mb_a_src", 16'(alu_a_src), 2);
            chk("mb_b_src", 16'(alu_b_src), 1);
            chk("mb_hazard", hazard_cnt, 1);
            tick();
        end
        mem_busy = 1'b0;
        #1;
        chk("mb_rel_stall", 16'(stall), 0);
        chk("mb_rel_issue", 16'(issue), 1);
        chk("mb_rel_a", 16'(alu_a_src), 2);
        chk("mb_rel_b", 16'(alu_b_src), 1);
        tick();
        dec(1, 12, 1, 11, 1, 13, 1, 0);
        chk("mb_post_a", 16'(alu_a_src), 1);
        chk("mb_post_b", 16'(alu_b_src), 2);
        tick();

        // Branch redirect: 3-cycle flush, slots drained
        br_taken = 1'b1;
        dec(1, 0, 0, 0, 0, 14, 1, 0);
        chk("br_no_comb_flush", 16'(flush), 0);
        chk("br_issue", 16'(issue), 1);
        tick();
        br_taken = 1'b0;
        dec(1, 14, 1, 13, 1, 15, 1, 0);
        for (int i = 0; i < 3; i++) begin
            chk("br_flush", 16'(flush), 1);
            chk("br_flush_issue", 16'(issue), 0);
            tick();
        end
        chk("br_end_flush", 16'(flush), 0);
        chk("br_end_issue", 16'(issue), 1);
        chk("br_drain_a", 16'(alu_a_src), 0);
        chk("br_drain_b", 16'(alu_b_src), 0);
        tick();

        // Retrigger in flush cycle 2
        br_taken = 1'b1;
        dec(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        br_taken = 1'b0;
        chk("rt_f1", 16'(flush), 1);
        tick();
        br_taken = 1'b1;
        #1;
        chk("rt_f2", 16'(flush), 1);
        tick();
        br_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rt_ext_flush", 16'(flush), 1);
            tick();
        end
        chk("rt_end_flush", 16'(flush), 0);

        // Async reset in the middle of a flush with back-pressure active
        dec(1, 0, 0, 0, 0, 20, 1, 0);
        tick();
        br_taken = 1'b1;
        dec(1, 20, 1, 0, 0, 21, 1, 0);
        tick();
        br_taken = 1'b0;
        mem_busy = 1'b1;
        dec(1, 21, 1, 20, 1, 22, 1, 0);
        chk("pr_flush", 16'(flush), 1);
        chk("pr_stall", 16'(stall), 1);
        chk("pr_a", 16'(alu_a_src), 1);
        chk("pr_b", 16'(alu_b_src), 2);
        chk("pr_hazard", hazard_cnt, 1);
        reset = 1'b0;
        #1;
        chk("ar_flush", 16'(flush), 0);
        chk("ar_stall", 16'(stall), 0);
        chk("ar_a", 16'(alu_a_src), 0);
        chk("ar_b", 16'(alu_b_src), 0);
        chk("ar_hazard", hazard_cnt, 0);
        chk("ar_issue", 16'(issue), 0);
        mem_busy = 1'b0;
        tick();
        reset = 1'b1;
        dec(1, 0, 0, 0, 0, 22, 1, 0);
        chk("post_rst_issue", 16'(issue), 1);
        chk("post_rst_flush", 16'(flush), 0);
        tick();
        dec(1, 22, 1, 0, 0, 23, 1, 0);
        chk("post_rst_fwd", 16'(alu_a_src), 1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
